// File: rtl/dmem_resp_rv32_if.sv
// Request/response bundle between the memory-access stage (master) and dmem_resp_rv32 (slave).
interface dmem_resp_rv32_if;
  logic        iReq;
  logic        iRW;
  logic [1:0]  iSize;
  logic [31:0] iADDR;
  logic [31:0] iWDATA;
  logic [31:0] oRDATA;
  logic        oStallD;
  logic        oAck;
  logic        oMisalign;

  modport master (
    output iReq, iRW, iSize, iADDR, iWDATA,
    input  oRDATA, oStallD, oAck, oMisalign
  );

  modport slave (
    input  iReq, iRW, iSize, iADDR, iWDATA,
    output oRDATA, oStallD, oAck, oMisalign
  );
endinterface

// File: rtl/dmem_resp_rv32.sv
// Data memory with programmable wait states, byte/half/word lanes and misalignment rejection.
// Accesses are serialized: one request at a time, completion signalled by a single oAck pulse.
module dmem_resp_rv32 #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  dmem_resp_rv32_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t            state, stateNxt_c;
  logic [CNT_W-1:0]  cnt, cntNxt_c;
  req_t              reqQ, live_c, acc_c;
  logic              liveMisalign_c;
  logic              accessNow_c;
  logic              stallNxt_c, ackNxt_c, misNxt_c;
  logic              stallQ, ackQ, misQ;
  logic [31:0]       rdataQ;
  logic [31:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [31:0]       rdWord_c, laneRead_c, wrData_c;
  logic [7:0]        rdByte_c;
  logic [15:0]       rdHalf_c;
  logic [3:0]        byteEn_c;
  logic              unusedAddrHi_c;

  // Upper address bits alias onto the array and are intentionally dropped.
  assign unusedAddrHi_c = ^bus.iADDR[31:ADDR_W];

  assign live_c = '{rw: bus.iRW, size: bus.iSize, addr: bus.iADDR[ADDR_W-1:0], wdata: bus.iWDATA};

  always_comb begin
    liveMisalign_c = 1'b0;
    case (bus.iSize)
      SZ_BYTE: liveMisalign_c = 1'b0;
      SZ_HALF: liveMisalign_c = bus.iADDR[0];
      SZ_WORD: liveMisalign_c = (bus.iADDR[1:0] != 2'b00);
      default: liveMisalign_c = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt_c;
      cnt   <= cntNxt_c;
    end
  end

  // Next-state logic
  always_comb begin
    stateNxt_c = state;
    cntNxt_c   = cnt;
    case (state)
      IDLE: begin
        if (bus.iReq) begin
          if (liveMisalign_c || (WAIT_CYCLES == 0)) begin
            stateNxt_c = RESP;
          end else begin
            stateNxt_c = WAIT;
            cntNxt_c   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) stateNxt_c = RESP;
        else           cntNxt_c   = cnt - CNT_W'(1);
      end
      RESP:    stateNxt_c = IDLE;
      default: stateNxt_c = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the array strobe
  always_comb begin
    stallNxt_c  = 1'b0;
    ackNxt_c    = 1'b0;
    misNxt_c    = 1'b0;
    accessNow_c = 1'b0;
    acc_c       = reqQ;
    if (state == IDLE) acc_c = live_c;
    stallNxt_c  = (stateNxt_c == WAIT);
    ackNxt_c    = (stateNxt_c == RESP);
    misNxt_c    = (state == IDLE) && bus.iReq && liveMisalign_c;
    accessNow_c = ackNxt_c && !misNxt_c;
  end

  // Lane steering for both directions
  always_comb begin
    idx_c    = acc_c.addr[ADDR_W-1:2];
    rdWord_c = mem[idx_c];
    rdByte_c = rdWord_c[7:0];
    case (acc_c.addr[1:0])
      2'd0:    rdByte_c = rdWord_c[7:0];
      2'd1:    rdByte_c = rdWord_c[15:8];
      2'd2:    rdByte_c = rdWord_c[23:16];
      default: rdByte_c = rdWord_c[31:24];
    endcase
    rdHalf_c   = acc_c.addr[1] ? rdWord_c[31:16] : rdWord_c[15:0];
    laneRead_c = rdWord_c;
    wrData_c   = acc_c.wdata;
    byteEn_c   = 4'b1111;
    case (acc_c.size)
      SZ_BYTE: begin
        laneRead_c = {24'h0, rdByte_c};
        wrData_c   = {4{acc_c.wdata[7:0]}};
        byteEn_c   = 4'b0001 << acc_c.addr[1:0];
      end
      SZ_HALF: begin
        laneRead_c = {16'h0, rdHalf_c};
        wrData_c   = {2{acc_c.wdata[15:0]}};
        byteEn_c   = acc_c.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        laneRead_c = rdWord_c;
        wrData_c   = acc_c.wdata;
        byteEn_c   = 4'b1111;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stallQ <= 1'b0;
      ackQ   <= 1'b0;
      misQ   <= 1'b0;
      rdataQ <= 32'h0;
    end else begin
      stallQ <= stallNxt_c;
      ackQ   <= ackNxt_c;
      misQ   <= misNxt_c;
      if (accessNow_c && acc_c.rw) rdataQ <= laneRead_c;
    end
  end

  // Request capture; datapath only, so no reset
  always_ff @(posedge iCLK) begin
    if ((state == IDLE) && bus.iReq) reqQ <= live_c;
  end

  // Array survives reset; a reset edge suppresses any completing write
  always_ff @(posedge iCLK) begin
    if (!iRST && accessNow_c && !acc_c.rw) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_c[i]) mem[idx_c][8*i +: 8] <= wrData_c[8*i +: 8];
      end
    end
  end

  assign bus.oStallD   = stallQ;
  assign bus.oAck      = ackQ;
  assign bus.oMisalign = misQ;
  assign bus.oRDATA    = rdataQ;

endmodule

// File: tb/tb_dmem_resp_rv32.sv
// Directed bench for dmem_resp_rv32: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_resp_rv32;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  dmem_resp_rv32_if busA ();
  dmem_resp_rv32_if busB ();

  dmem_resp_rv32 #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dutA (.iCLK(iCLK), .iRST(iRST), .bus(busA));
  dmem_resp_rv32 #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dutB (.iCLK(iCLK), .iRST(iRST), .bus(busB));

  int   checks = 0;
  int   errors = 0;
  int   stalls;
  int   ackCyc;
  logic mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance A from a negedge; returns at the negedge after the ack cycle.
  task automatic accessA(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    busA.iReq = 1'b1; busA.iRW = rw; busA.iSize = sz; busA.iADDR = a; busA.iWDATA = wd;
    @(negedge iCLK);
    busA.iReq = 1'b0;
    stalls = 0; ackCyc = 0; mis = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busA.oStallD) stalls++;
      if (busA.oAck) begin
        ackCyc = i;
        mis    = busA.oMisalign;
        break;
      end
      @(negedge iCLK);
    end
    @(negedge iCLK);
  endtask

  initial begin
    iRST = 1'b1;
    busA.iReq = 1'b0; busA.iRW = 1'b0; busA.iSize = 2'b10; busA.iADDR = '0; busA.iWDATA = '0;
    busB.iReq = 1'b0; busB.iRW = 1'b0; busB.iSize = 2'b10; busB.iADDR = '0; busB.iWDATA = '0;
    repeat (2) @(negedge iCLK);
    chk("rst_stall", 32'(busA.oStallD), 32'h0);
    chk("rst_ack",   32'(busA.oAck), 32'h0);
    chk("rst_mis",   32'(busA.oMisalign), 32'h0);
    chk("rst_rdata", busA.oRDATA, 32'h0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Word write then read back with two wait states
    accessA(1'b0, 2'b10, 32'h10, 32'hDEADBEEF);
    chk("wr10_ackcyc", 32'(ackCyc), 32'd3);
    chk("wr10_stalls", 32'(stalls), 32'd2);
    chk("wr10_mis",    32'(mis), 32'h0);
    chk("wr10_rdata",  busA.oRDATA, 32'h0);
    accessA(1'b1, 2'b10, 32'h10, 32'h0);
    chk("rd10_ackcyc", 32'(ackCyc), 32'd3);
    chk("rd10_stalls", 32'(stalls), 32'd2);
    chk("rd10_rdata",  busA.oRDATA, 32'hDEADBEEF);

    // Byte lane merge and narrow reads
    accessA(1'b0, 2'b00, 32'h13, 32'hFFFFFFA5);
    accessA(1'b1, 2'b10, 32'h10, 32'h0);
    chk("rd10_merged", busA.oRDATA, 32'hA5ADBEEF);
    accessA(1'b1, 2'b00, 32'h13, 32'h0);
    chk("rdb13", busA.oRDATA, 32'h000000A5);
    accessA(1'b1, 2'b01, 32'h12, 32'h0);
    chk("rdh12", busA.oRDATA, 32'h0000A5AD);
    accessA(1'b1, 2'b01, 32'h10, 32'h0);
    chk("rdh10", busA.oRDATA, 32'h0000BEEF);

    // Misaligned accesses: immediate ack, no stall, no array or rdata change
    accessA(1'b1, 2'b01, 32'h11, 32'h0);
    chk("mis_h11_ackcyc", 32'(ackCyc), 32'd1);
    chk("mis_h11_flag",   32'(mis), 32'h1);
    chk("mis_h11_stalls", 32'(stalls), 32'd0);
    chk("mis_h11_rdata",  busA.oRDATA, 32'h0000BEEF);
    chk("mis_clear_idle", 32'(busA.oMisalign), 32'h0);
    accessA(1'b0, 2'b10, 32'h12, 32'h11111111);
    chk("mis_w12_flag", 32'(mis), 32'h1);
    accessA(1'b0, 2'b11, 32'h10, 32'h22222222);
    chk("mis_sz3_flag", 32'(mis), 32'h1);
    accessA(1'b1, 2'b10, 32'h10, 32'h0);
    chk("mis_nowrite", busA.oRDATA, 32'hA5ADBEEF);
    chk("aligned_mis0", 32'(mis), 32'h0);
    accessA(1'b0, 2'b01, 32'h12, 32'h0000C3C3);
    accessA(1'b1, 2'b10, 32'h10, 32'h0);
    chk("half_write", busA.oRDATA, 32'hC3C3BEEF);

    // Reset during WAIT aborts the write
    accessA(1'b0, 2'b10, 32'h20, 32'h11112222);
    busA.iReq = 1'b1; busA.iRW = 1'b0; busA.iSize = 2'b10; busA.iADDR = 32'h20; busA.iWDATA = 32'h12345678;
    @(negedge iCLK);
    busA.iReq = 1'b0;
    chk("abort_inwait", 32'(busA.oStallD), 32'h1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("abort_stall", 32'(busA.oStallD), 32'h0);
    chk("abort_ack",   32'(busA.oAck), 32'h0);
    chk("abort_mis",   32'(busA.oMisalign), 32'h0);
    chk("abort_rdata", busA.oRDATA, 32'h0);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    accessA(1'b1, 2'b10, 32'h20, 32'h0);
    chk("abort_keep", busA.oRDATA, 32'h11112222);
    accessA(1'b1, 2'b10, 32'h10, 32'h0);
    chk("reset_keeps_array", busA.oRDATA, 32'hC3C3BEEF);

    // Upper address bits alias onto the array
    accessA(1'b0, 2'b10, 32'h400, 32'h0000CAFE);
    accessA(1'b1, 2'b10, 32'h000, 32'h0);
    chk("alias_rd0", busA.oRDATA, 32'h0000CAFE);

    // Zero wait states with iReq held high: accept every other cycle
    busB.iReq = 1'b1; busB.iRW = 1'b0; busB.iSize = 2'b10; busB.iADDR = 32'h4; busB.iWDATA = 32'h000055AA;
    for (int k = 1; k <= 6; k++) begin
      @(negedge iCLK);
      chk($sformatf("b_ack_%0d", k), 32'(busB.oAck), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("b_stall_%0d", k), 32'(busB.oStallD), 32'h0);
    end
    busB.iReq = 1'b0;
    @(negedge iCLK);
    busB.iReq = 1'b1; busB.iRW = 1'b1; busB.iADDR = 32'h4;
    @(negedge iCLK);
    busB.iReq = 1'b0;
    chk("b_rd_ack",   32'(busB.oAck), 32'h1);
    chk("b_rd_rdata", busB.oRDATA, 32'h000055AA);
    @(negedge iCLK);
    chk("b_rd_ackdrop", 32'(busB.oAck), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
